// File: rtl/unary_acc_pkg.sv
// ============================================================================
// Module   : unary_acc_pkg
// Purpose  : Shared types and helpers for the unary-stream window accumulator.
//            Provides the FSM state type, the window-length function and the
//            window-counter width for the default operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package unary_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default upstream operand width and its window-counter width (WIDTH-1).
  localparam int DEFAULT_WIDTH = 8;
  localparam int WCNT_W        = DEFAULT_WIDTH - 1;

  // Window length in cycles for a given operand width.
  function automatic int win_len(input int width);
    return 1 << (width - 1);
  endfunction

  // Window-counter width for a given operand width: it counts 0..WIN-1.
  function automatic int wcnt_width(input int width);
    return width - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/unary_win_cnt.sv
// ============================================================================
// Module   : unary_win_cnt
// Purpose  : Window counter plus ones counter for one computation window.
//            The window counter runs over WIN = 2^(WIDTH-1) enabled cycles;
//            the ones counter accumulates i_bit over the same cycles.
// Ports    : clk    - clock
//            rst_n  - synchronous active-low reset
//            clear  - zero both counters (start of a window)
//            en     - count this cycle (window in progress)
//            i_bit  - unary stream bit
//            count  - ones seen so far in the window (excludes this cycle)
//            last   - this enabled cycle is the final cycle of the window
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unary_win_cnt
  import unary_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  localparam int CW = wcnt_width(WIDTH);

  logic [CW-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt  <= '0;
      count <= '0;
    end else if (clear) begin
      wcnt  <= '0;
      count <= '0;
    end else if (en) begin
      wcnt  <= wcnt + CW'(1);
      // Range is 0..WIN and WIN = 2^(WIDTH-1), so WIDTH bits never overflow.
      count <= count + WIDTH'(i_bit);
    end
  end

  // Window counter all-ones means WIN-1 cycles already counted.
  assign last = en & (&wcnt);

endmodule

`default_nettype wire

// File: rtl/unary_acc_window.sv
// ============================================================================
// Module   : unary_acc_window
// Purpose  : Counts the ones of a unary product stream over a window of
//            WIN = 2^(WIDTH-1) cycles, applies the product sign and adds the
//            signed magnitude into a running two's-complement accumulator.
// Config   : UNARY_ACC_SAT_EN - saturating accumulation with sticky o_sat;
//            when undefined the accumulator wraps and o_sat stays 0.
// Ports    : clk      - clock
//            rst_n    - synchronous active-low reset
//            i_start  - start a window (accepted in IDLE or DONE)
//            i_clear  - with accepted start: result replaces accumulator
//            i_sign   - with accepted start: product sign
//            i_bit    - unary product stream
//            o_busy   - window in progress
//            o_valid  - one-cycle result pulse
//            o_prod   - ones count of last window (unsigned)
//            o_acc    - signed accumulator
//            o_sat    - sticky saturation flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unary_acc_window
  import unary_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACCW  = 24   // must exceed WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_sign,
  input  logic             i_bit,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_prod,
  output logic [ACCW-1:0]  o_acc,
  output logic             o_sat
);

  state_t           state;
  logic             sign_q;
  logic             clear_q;
  logic             sat_q;
  logic [WIDTH-1:0] count;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] fin;
  logic [ACCW-1:0]  mag;
  logic [ACCW-1:0]  delta;
  logic [ACCW-1:0]  base;
  logic [ACCW-1:0]  acc_next;
  logic             ovf;

  assign accept = i_start & ((state == ST_IDLE) | (state == ST_DONE));

  unary_win_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .en    (state == ST_RUN),
    .i_bit (i_bit),
    .count (count),
    .last  (last)
  );

  // Final count includes the bit sampled on the closing edge, so the result
  // registers on that edge and is visible during the DONE cycle.
  assign fin   = count + WIDTH'(i_bit);
  assign mag   = {{(ACCW-WIDTH){1'b0}}, fin};
  assign delta = sign_q ? -mag : mag;   // zero stays zero when negated
  assign base  = clear_q ? '0 : o_acc;

`ifdef UNARY_ACC_SAT_EN
  logic [ACCW:0] sum_ext;

  assign sum_ext  = {base[ACCW-1], base} + {delta[ACCW-1], delta};
  // Overflow when the extra sign bit disagrees with the ACCW-bit sign.
  assign ovf      = sum_ext[ACCW] ^ sum_ext[ACCW-1];
  assign acc_next = !ovf         ? sum_ext[ACCW-1:0] :
                    sum_ext[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} :
                                    {1'b0, {(ACCW-1){1'b1}}};
`else
  assign ovf      = 1'b0;
  assign acc_next = base + delta;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sign_q  <= 1'b0;
      clear_q <= 1'b0;
      sat_q   <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_prod  <= '0;
      o_acc   <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            sign_q  <= i_sign;
            clear_q <= i_clear;
            o_busy  <= 1'b1;
            state   <= ST_RUN;
          end else begin
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (last) begin
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
            o_prod  <= fin;
            o_acc   <= acc_next;
            sat_q   <= sat_q | ovf;
            state   <= ST_DONE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sat = sat_q;

endmodule

`default_nettype wire
